fastram_arbiter: RTL and testbench
==================================

// Module: fastram_arbiter
// PURPOSE
//  Shares the single fastram SDRAM port (23-bit byte address, banks 00-7E) between the 65C816 CPU path and
//  the HDD block-transfer (DMA) path. Sequences one access at a time with a req/ready handshake to the SDRAM
//  controller, stalls the CPU via cpu_wait, and bounds DMA starvation and SDRAM hangs.
//  Sits in top between the bank/address decode (fastram_ce region) and the fastram_* SDRAM signals.
// PARAMETERS
//  CPU_BURST_MAX  4    consecutive CPU grants allowed while dma_req pending before DMA is forced a slot (1..15)
//  TIMEOUT        64   cycles in an access state without fastram_ready before forced completion; 0 = disabled
// PORTS
//  clk_sys          in   1   system clock; all logic on rising edge
//  reset            in   1   asynchronous, active-high reset
//  cpu_req          in   1   CPU access request, level, held until cpu_ack
//  cpu_we           in   1   1 = write, 0 = read
//  cpu_addr         in   23  {bank[6:0], raddr}
//  cpu_din          in   8   CPU write data
//  cpu_dout         out  8   CPU read data, valid with cpu_ack
//  cpu_ack          out  1   one-cycle completion pulse
//  cpu_wait         out  1   cpu_req & ~cpu_ack (combinational), stalls CPU
//  dma_req/dma_we   in   1   HDD DMA request / write enable, same rules as CPU
//  dma_addr         in   23  DMA address
//  dma_din          in   8   DMA write data
//  dma_dout         out  8   DMA read data, valid with dma_ack
//  dma_ack          out  1   one-cycle completion pulse
//  fastram_address  out  23  latched address to SDRAM
//  fastram_datatoram out 8   latched write data
//  fastram_datafromram in 8  SDRAM read data, valid with fastram_ready
//  fastram_we       out  1   latched write enable, valid while fastram_ce
//  fastram_ce       out  1   access request, high for whole access
//  fastram_ready    in   1   one-cycle pulse from SDRAM: access done
//  timeout_err      out  1   sticky: an access timed out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (cpu_wait follows cpu_req); streak=0, timer=0, timeout_err=0.
//   Reset mid-access: fastram_ce drops immediately, no ack issued, access abandoned.
//  States: IDLE -> CPU_ACC | DMA_ACC -> DONE -> IDLE. All outputs registered except cpu_wait.
//  IDLE: sample reqs. Only one -> grant it. Both -> CPU unless streak==CPU_BURST_MAX, then DMA.
//   Grant latches addr/din/we into fastram_* and sets fastram_ce next cycle (request cycle N -> ce at N+1).
//  Streak: on CPU grant with dma_req high -> streak+1 (saturating); on CPU grant with dma_req low or any
//   DMA grant -> 0.
//  *_ACC: fastram_* held stable; timer counts up from 0. fastram_ready -> DONE, latch
//   fastram_datafromram into granted *_dout (reads only; writes leave *_dout unchanged).
//   timer==TIMEOUT-1 without ready (TIMEOUT!=0) -> DONE, *_dout=8'hFF on read, timeout_err<=1.
//   ready and timeout in same cycle: ready wins, no error.
//  DONE: fastram_ce=0, granted *_ack=1 for exactly this cycle; next state IDLE. Ungranted ack stays 0.
//  Requester must drop req by the cycle after ack; req still high at ack+1 = new request.
//  Minimum access = 3 cycles (grant, ready same cycle ce seen, ack); back-to-back grant every 3+ cycles.
//  fastram_ready outside *_ACC ignored. Address wrap not applicable (pass-through, no arithmetic).
// TESTING
//  CPU read alone, ready 2 cycles after ce, data 8'h5A -> ce 2 cycles, cpu_ack 1 pulse, cpu_dout=8'h5A.
//  CPU write addr 23'h01_2345 data 8'hC3 -> fastram_we=1, address/data stable whole ce, cpu_dout unchanged.
//  CPU+DMA both held, CPU_BURST_MAX=4 -> grant order C,C,C,C,D,C,C,C,C,D; dma never starved.
//  ready never arrives, TIMEOUT=64 -> ack at cycle 64 after ce, dout=8'hFF, timeout_err=1 until reset.
//  reset asserted mid CPU_ACC -> ce=0 at once, no cpu_ack; after release DMA req granted normally.
//  ready coincident with timeout and spurious ready in IDLE -> normal data, no err; IDLE ready ignored.

Source files
------------

// File: rtl/fastram_arbiter.sv
// Arbitrates the single fastram SDRAM port between the CPU and HDD DMA paths,
// one access at a time, with bounded DMA starvation and an access timeout.
module fastram_arbiter #(
  parameter int CPU_BURST_MAX = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_ack,
  output logic [22:0] fastram_address,
  output logic [7:0]  fastram_datatoram,
  input  logic [7:0]  fastram_datafromram,
  output logic        fastram_we,
  output logic        fastram_ce,
  input  logic        fastram_ready,
  output logic        timeout_err
);

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]      STREAK_MAX = 4'(CPU_BURST_MAX);
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DONE} state_t;

  state_t        state;
  logic [3:0]    streak;
  logic [TW-1:0] timer;
  logic          grant_cpu;
  logic          grant_dma;
  logic          timed_out;
  logic          finish;
  logic [7:0]    rd_data;

  // DMA only wins a contested slot once the CPU has used up its burst allowance.
  always_comb begin
    grant_dma = dma_req && (!cpu_req || streak == STREAK_MAX);
    grant_cpu = cpu_req && !grant_dma;
    timed_out = TIMEOUT_EN && (timer == TIMER_LAST) && !fastram_ready;
    finish    = fastram_ready || timed_out;
    rd_data   = fastram_ready ? fastram_datafromram : 8'hFF;
  end

  assign cpu_wait = cpu_req & ~cpu_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      streak            <= 4'd0;
      timer             <= '0;
      cpu_dout          <= 8'h00;
      cpu_ack           <= 1'b0;
      dma_dout          <= 8'h00;
      dma_ack           <= 1'b0;
      fastram_address   <= 23'd0;
      fastram_datatoram <= 8'h00;
      fastram_we        <= 1'b0;
      fastram_ce        <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (grant_cpu || grant_dma) begin
            fastram_ce        <= 1'b1;
            fastram_address   <= grant_dma ? dma_addr : cpu_addr;
            fastram_datatoram <= grant_dma ? dma_din  : cpu_din;
            fastram_we        <= grant_dma ? dma_we   : cpu_we;
            state             <= grant_dma ? DMA_ACC  : CPU_ACC;
          end
          if (grant_dma) begin
            streak <= 4'd0;
          end else if (grant_cpu) begin
            if (!dma_req)
              streak <= 4'd0;
            else if (streak != 4'hF)
              streak <= streak + 4'd1;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (finish) begin
            fastram_ce <= 1'b0;
            state      <= DONE;
            if (timed_out)
              timeout_err <= 1'b1;
            if (state == CPU_ACC) begin
              cpu_ack <= 1'b1;
              if (!fastram_we)
                cpu_dout <= rd_data;
            end else begin
              dma_ack <= 1'b1;
              if (!fastram_we)
                dma_dout <= rd_data;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fastram_arbiter.sv
// Directed plus randomized bench for fastram_arbiter: an SDRAM memory model
// answers each access, and the arbitration policy is predicted from the grant rules.
module tb_fastram_arbiter;

  localparam int CPU_BURST_MAX = 4;
  localparam int TIMEOUT       = 64;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we  = 1'b0;
  logic [22:0] cpu_addr = 23'd0;
  logic [7:0]  cpu_din  = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait;
  logic        dma_req = 1'b0;
  logic        dma_we  = 1'b0;
  logic [22:0] dma_addr = 23'd0;
  logic [7:0]  dma_din  = 8'h00;
  logic [7:0]  dma_dout;
  logic        dma_ack;
  logic [22:0] fastram_address;
  logic [7:0]  fastram_datatoram;
  logic [7:0]  fastram_datafromram = 8'h00;
  logic        fastram_we;
  logic        fastram_ce;
  logic        fastram_ready = 1'b0;
  logic        timeout_err;

  always #5 clk_sys = ~clk_sys;

  fastram_arbiter #(.CPU_BURST_MAX(CPU_BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_dout(dma_dout), .dma_ack(dma_ack),
    .fastram_address(fastram_address), .fastram_datatoram(fastram_datatoram),
    .fastram_datafromram(fastram_datafromram), .fastram_we(fastram_we),
    .fastram_ce(fastram_ce), .fastram_ready(fastram_ready), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [logic [22:0]];
  int          ready_delay  = 1;
  bit          rand_delay   = 1'b0;
  bit          inject_ready = 1'b0;
  int          ce_cnt       = 0;
  int          cur_delay    = 0;
  logic [22:0] ce_addr      = 23'd0;
  logic [7:0]  ce_data      = 8'h00;
  logic        ce_we        = 1'b0;

  logic [7:0]  exp_cpu_dout = 8'h00;
  logic [7:0]  exp_dma_dout = 8'h00;
  logic        exp_err      = 1'b0;
  int          streak       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [22:0] a);
    if (mem.exists(a))
      return mem[a];
    return a[7:0] ^ {1'b0, a[22:16]};
  endfunction

  // One clock of the SDRAM model: ready arrives in the cur_delay-th ce cycle (0 = never).
  task automatic tick();
    @(negedge clk_sys);
    if (reset || !fastram_ce) begin
      ce_cnt              = 0;
      fastram_ready       = inject_ready;
      fastram_datafromram = inject_ready ? 8'hEE : 8'h00;
    end else begin
      ce_cnt++;
      if (ce_cnt == 1) begin
        cur_delay = rand_delay ? int'($urandom_range(1, 4)) : ready_delay;
        ce_addr   = fastram_address;
        ce_data   = fastram_datatoram;
        ce_we     = fastram_we;
      end else begin
        check("ce_stable", {fastram_we, fastram_datatoram, fastram_address},
              {ce_we, ce_data, ce_addr});
      end
      if (ce_cnt == cur_delay) begin
        fastram_ready = 1'b1;
        if (fastram_we) begin
          mem[fastram_address] = fastram_datatoram;
          fastram_datafromram  = 8'h00;
        end else begin
          fastram_datafromram = mem_rd(fastram_address);
        end
      end else begin
        fastram_ready       = 1'b0;
        fastram_datafromram = 8'($urandom);
      end
    end
  endtask

  // Waits for one granted access to complete; dly<0 means latency not checked.
  task automatic serve(input bit is_dma, input bit we, input logic [22:0] addr,
                       input logic [7:0] din, input int dly, input bit first);
    int    n;
    int    n_ce;
    bit    got;
    string who;
    logic [7:0] exp_d;
    n = 0; n_ce = -1; got = 1'b0;
    who = is_dma ? "dma" : "cpu";
    while (!got && n < 300) begin
      tick();
      n++;
      if (fastram_ce && n_ce < 0) begin
        n_ce = n;
        check({who, "_grant_lat"}, 32'(n_ce), first ? 32'd1 : 32'd2);
        check({who, "_addr"}, 32'(fastram_address), 32'(addr));
        check({who, "_we"}, 32'(fastram_we), 32'(we));
        if (we)
          check({who, "_wdata"}, 32'(fastram_datatoram), 32'(din));
      end
      if (is_dma ? cpu_ack : dma_ack)
        check({who, "_other_ack"}, 32'(is_dma ? cpu_ack : dma_ack), 32'd0);
      got = is_dma ? dma_ack : cpu_ack;
    end
    check({who, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (dly >= 0)
        check({who, "_ack_lat"}, 32'(n - n_ce), 32'((dly == 0) ? TIMEOUT : dly));
      exp_d = (dly == 0) ? 8'hFF : mem_rd(addr);
      if (dly == 0)
        exp_err = 1'b1;
      if (is_dma) begin
        if (!we) exp_dma_dout = exp_d;
        check("dma_dout", 32'(dma_dout), 32'(exp_dma_dout));
      end else begin
        if (!we) exp_cpu_dout = exp_d;
        check("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
      end
      check("timeout_err", 32'(timeout_err), 32'(exp_err));
    end
  endtask

  task automatic transact(input bit c_en, input bit c_we, input logic [22:0] c_addr,
                          input logic [7:0] c_din, input bit d_en, input bit d_we,
                          input logic [22:0] d_addr, input logic [7:0] d_din, input int dly);
    bit dma_first;
    $display("[TB] txn cpu=%0d/%0d %h dma=%0d/%0d %h dly=%0d",
             c_en, c_we, c_addr, d_en, d_we, d_addr, dly);
    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_addr; cpu_din = c_din;
    dma_req = d_en; dma_we = d_we; dma_addr = d_addr; dma_din = d_din;
    ready_delay = dly;
    #1;
    check("cpu_wait_req", 32'(cpu_wait), 32'(c_en));
    dma_first = d_en && (!c_en || streak == CPU_BURST_MAX);
    if (dma_first) begin
      serve(1'b1, d_we, d_addr, d_din, dly, 1'b1);
      dma_req = 1'b0;
      streak  = 0;
      if (c_en) begin
        serve(1'b0, c_we, c_addr, c_din, dly, 1'b0);
        cpu_req = 1'b0;
      end
    end else if (c_en) begin
      serve(1'b0, c_we, c_addr, c_din, dly, 1'b1);
      cpu_req = 1'b0;
      streak  = d_en ? ((streak < 15) ? streak + 1 : 15) : 0;
      if (d_en) begin
        serve(1'b1, d_we, d_addr, d_din, dly, 1'b0);
        dma_req = 1'b0;
        streak  = 0;
      end
    end
    tick();
    check("ack_pulse", 32'(cpu_ack | dma_ack), 32'd0);
    check("ce_idle", 32'(fastram_ce), 32'd0);
  endtask

  initial begin
    logic [22:0] pool [4];
    pool = '{23'h00_0010, 23'h7E_FFFF, 23'h12_3456, 23'h00_0011};

    // Reset state
    tick(); tick();
    check("rst_ce", 32'(fastram_ce), 32'd0);
    check("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_douts", 32'({cpu_dout, dma_dout}), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_addr", 32'(fastram_address), 32'd0);
    cpu_req = 1'b1; #1;
    check("rst_wait_hi", 32'(cpu_wait), 32'd1);
    cpu_req = 1'b0; #1;
    check("rst_wait_lo", 32'(cpu_wait), 32'd0);
    reset = 1'b0;
    tick();

    // Basic accesses
    mem[23'h00_1000] = 8'h5A;
    transact(1, 0, 23'h00_1000, 8'h00, 0, 0, 23'd0, 8'h00, 2);
    transact(1, 1, 23'h01_2345, 8'hC3, 0, 0, 23'd0, 8'h00, 3);
    transact(0, 0, 23'd0, 8'h00, 1, 0, 23'h01_2345, 8'h00, 1);

    // Both requesters held: DMA gets every (CPU_BURST_MAX+1)-th slot
    mem[23'h00_2000] = 8'h11;
    mem[23'h40_0000] = 8'h22;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h00_2000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h40_0000;
    rand_delay = 1'b1;
    for (int g = 0; g < 10; g++) begin
      bit is_d;
      is_d = (streak == CPU_BURST_MAX);
      $display("[TB] txn held grant %0d expect %s", g, is_d ? "D" : "C");
      serve(is_d, 1'b0, is_d ? 23'h40_0000 : 23'h00_2000, 8'h00, -1, g == 0);
      streak = is_d ? 0 : streak + 1;
      if (g == 9) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    rand_delay = 1'b0;
    tick();
    check("held_end_ce", 32'(fastram_ce), 32'd0);

    // Ready on the very cycle the timeout would fire: data wins, no error
    mem[23'h00_3000] = 8'h3C;
    transact(1, 0, 23'h00_3000, 8'h00, 0, 0, 23'd0, 8'h00, TIMEOUT);

    // Spurious ready while idle is ignored
    inject_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_ce", 32'(fastram_ce), 32'd0);
      check("spur_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    end
    inject_ready = 1'b0;
    tick();
    check("spur_cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
    check("spur_dma_dout", 32'(dma_dout), 32'(exp_dma_dout));

    // Randomized single and contested accesses
    for (int i = 0; i < 20; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      transact(kind != 1, 1'($urandom), pool[$urandom_range(0, 3)], 8'($urandom),
               kind != 0, 1'($urandom), pool[$urandom_range(0, 3)], 8'($urandom),
               int'($urandom_range(1, 6)));
    end

    // Timeout, then error stays sticky across a normal access
    transact(1, 0, 23'h05_5555, 8'h00, 0, 0, 23'd0, 8'h00, 0);
    transact(0, 0, 23'd0, 8'h00, 1, 1, 23'h05_5555, 8'h77, 1);

    // Reset in the middle of a CPU access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h06_0000;
    ready_delay = 0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_ce_before", 32'(fastram_ce), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_ce_drop", 32'(fastram_ce), 32'd0);
    check("mid_no_ack", 32'(cpu_ack), 32'd0);
    check("mid_err_clr", 32'(timeout_err), 32'd0);
    cpu_req = 1'b0;
    exp_err = 1'b0; exp_cpu_dout = 8'h00; exp_dma_dout = 8'h00; streak = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("post_rst_ack", 32'(cpu_ack | dma_ack), 32'd0);
    mem[23'h06_0001] = 8'hA5;
    transact(0, 0, 23'd0, 8'h00, 1, 0, 23'h06_0001, 8'h00, 2);
    check("post_rst_cpu_dout", 32'(cpu_dout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
